fetch_decode_unit: RTL and testbench
====================================

FETCH_DECODE_UNIT -- requirements
Module: fetch_decode_unit

Interface
REQ-001 Parameter: DATA_W, 8, register/ALU data width; only 8 is supported.
REQ-002 Parameter: ADDR_W, 8, instruction address width; only 8 is supported.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous and active-high.
REQ-005 Port: start  input  1  one-cycle request to run the program from address 0.
REQ-006 Port: address  output  8  program counter driven to instruction memory.
REQ-007 Port: instruction  input  16  combinational instruction-memory read data for the current address.
REQ-008 Port: rdAddrA  output  4  register-file read address A, equal to IR[7:4].
REQ-009 Port: rdAddrB  output  4  register-file read address B, equal to IR[3:0].
REQ-010 Port: rdDataA  input  8  combinational register-file data for rdAddrA.
REQ-011 Port: rdDataB  input  8  combinational register-file data for rdAddrB.
REQ-012 Port: wrEn  output  1  register-file write strobe, one cycle per writing instruction.
REQ-013 Port: wrAddr  output  4  write destination, equal to IR[11:8].
REQ-014 Port: wrData  output  8  write data.
REQ-015 Port: busy  output  1  high in FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-016 Port: halted  output  1  high in HALT state.

Function
REQ-017 FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; non-halt instructions take exactly 4 cycles.
REQ-018 IDLE: start=1 -> PC=0 and go to FETCH; otherwise stay.
REQ-019 FETCH: IR <= instruction at address=PC; go to DECODE.
REQ-020 DECODE: rdAddrA/rdAddrB are driven from IR; go to EXECUTE; opcode 1110 goes to HALT instead, and PC is not advanced.
REQ-021 EXECUTE: result register <= f(opcode, IR, rdDataA, rdDataB); go to WRITEBACK.
REQ-022 WRITEBACK: wrEn=1 for writing opcodes; wrAddr=IR[11:8]; wrData=result; PC <= PC+1; go to FETCH.
REQ-023 Opcode 0000 SET: result = IR[7:0].
REQ-024 Opcode 0010 COPY: result = rdDataA.
REQ-025 Opcode 0100 ADD: result = (rdDataA + rdDataB) mod 256; carry is discarded.
REQ-026 Opcode 0101 NEG: result = (~rdDataA + 1) mod 256.
REQ-027 Opcode 0110 AND: result = rdDataA & rdDataB.
REQ-028 Opcode 0111 OR: result = rdDataA | rdDataB.
REQ-029 Opcode 1000 SHL: result = {rdDataA[6:0], 0}.
REQ-030 Opcode 1011 GT: result = 1 if rdDataA > rdDataB (unsigned), else 0.
REQ-031 Any other opcode is a NOP: it takes the full 4 cycles, wrEn stays 0, and PC advances.
REQ-032 PC wrap: WRITEBACK at PC=255 sets PC=0 and execution continues.
REQ-033 start while busy is ignored.
REQ-034 HALT: busy=0, halted=1, and wrEn=0; start=1 -> clear halted, PC=0, go to FETCH.
REQ-035 wrEn is 0 in every state except WRITEBACK.
REQ-036 address equals PC at all times.

Reset
REQ-037 On reset assertion, with no clock edge required: state=IDLE, PC=0, IR=0, result=0, wrEn=0, busy=0, halted=0.
REQ-038 While reset is asserted, address=0, rdAddrA=0, rdAddrB=0, wrAddr=0 and wrData=0.
REQ-039 Reset asserted mid-instruction aborts that instruction; no write is issued.
REQ-040 After reset deassertion, the unit waits in IDLE for start.

Verification
REQ-041 Program {0000_0001_0000_0010, 0010_1111_0001_0000, 0000_0010_0000_0011, 0100_1111_0010_0001, 1110_x} -> writes (R1,2), (R15,2), (R2,3), (R15,5), then halted=1 with address=4.
REQ-042 Model R7=10 and R8=0xFD, then run 0100_1111_0111_1000 -> wrData=0x07, wrAddr=15, with wrEn high exactly at cycle 4 after FETCH entry.
REQ-043 Run NEG of 3, SHL of 5, GT(5,3) and GT(3,5) -> wrData = 0xFD, 0x0A, 0x01, 0x00 respectively.
REQ-044 Program of 256 NOPs (opcode 0001) -> no wrEn pulses, address wraps 255->0, and busy stays 1.
REQ-045 Assert reset during EXECUTE of an ADD -> wrEn never pulses, outputs go to reset values immediately, and the unit stays IDLE until start.
REQ-046 Pulse start during DECODE -> no effect; pulse start in HALT -> halted falls and address=0 on the next cycle.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a 16-bit instruction set
// with an 8-bit datapath; the register file and instruction memory sit outside.
module fetch_decode_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] address,
    input  logic [15:0]       instruction,
    output logic [3:0]        rdAddrA,
    output logic [3:0]        rdAddrB,
    input  logic [DATA_W-1:0] rdDataA,
    input  logic [DATA_W-1:0] rdDataB,
    output logic              wrEn,
    output logic [3:0]        wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_SET  = 4'b0000;
    localparam logic [3:0] OP_COPY = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_NEG  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1110;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;
    logic [3:0]          opcode;

    assign opcode = ir_q[15:12];

    function automatic logic writes_reg(input logic [3:0] op);
        return op inside {OP_SET, OP_COPY, OP_ADD, OP_NEG, OP_AND, OP_OR, OP_SHL, OP_GT};
    endfunction

    function automatic logic [DATA_W-1:0] alu(input logic [3:0] op, input logic [15:0] ir,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            OP_SET:  r = ir[DATA_W-1:0];
            OP_COPY: r = a;
            OP_ADD:  r = a + b;
            OP_NEG:  r = ~a + DATA_W'(1);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SHL:  r = {a[DATA_W-2:0], 1'b0};
            OP_GT:   r = {{(DATA_W-1){1'b0}}, (a > b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE:    state_d = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (writes_reg(opcode)) result_d = alu(opcode, ir_q, rdDataA, rdDataB);
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
            default:     state_d = S_IDLE;
        endcase

        // Status outputs are registered from the next state so they line up with it.
        wr_en_d  = (state_d == S_WRITEBACK) && writes_reg(opcode);
        busy_d   = state_d inside {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK};
        halted_d = (state_d == S_HALT);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign address = pc_q;
    assign rdAddrA = ir_q[7:4];
    assign rdAddrB = ir_q[3:0];
    assign wrAddr  = ir_q[11:8];
    assign wrData  = result_q;
    assign wrEn    = wr_en_q;
    assign busy    = busy_q;
    assign halted  = halted_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: behavioural instruction memory and register
// file around the DUT, a table of single-instruction vectors and hand-written sequences.
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  address;
    logic [15:0] instruction;
    logic [3:0]  rdAddrA, rdAddrB, wrAddr;
    logic [7:0]  rdDataA, rdDataB, wrData;
    logic        wrEn, busy, halted;

    logic [15:0] imem [256];
    logic [7:0]  regs [16];

    int n_tests = 0;
    int n_fail  = 0;

    int         n_wr;
    int         first_wr_cyc;
    logic [3:0] wa_log [8];
    logic [7:0] wd_log [8];
    bit         end_halted;
    bit         busy_ok;
    bit         wrap_seen;
    logic [7:0] end_addr;

    typedef struct {
        logic [15:0] instr;
        int          exp_nwr;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    assign instruction = imem[address];
    assign rdDataA     = regs[rdAddrA];
    assign rdDataB     = regs[rdAddrB];

    fetch_decode_unit #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .address     (address),
        .instruction (instruction),
        .rdAddrA     (rdAddrA),
        .rdAddrB     (rdAddrB),
        .rdDataA     (rdDataA),
        .rdDataB     (rdDataB),
        .wrEn        (wrEn),
        .wrAddr      (wrAddr),
        .wrData      (wrData),
        .busy        (busy),
        .halted      (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic init_regs();
        for (int i = 0; i < 16; i++) regs[i] = 8'h00;
        regs[3] = 8'h03;
        regs[5] = 8'h05;
        regs[7] = 8'h0A;
        regs[8] = 8'hFD;
    endtask

    task automatic fill_imem(input logic [15:0] word);
        for (int i = 0; i < 256; i++) imem[i] = word;
    endtask

    // Pulses start, then samples every negedge (cycle 1 = FETCH of the first
    // instruction) until halted or the cycle budget runs out.
    task automatic run(input int max_cyc, input int start_at);
        logic [7:0] prev;
        n_wr         = 0;
        first_wr_cyc = 0;
        end_halted   = 1'b0;
        busy_ok      = 1'b1;
        wrap_seen    = 1'b0;
        end_addr     = 8'h00;
        prev         = address;
        start        = 1'b1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (wrEn) begin
                if (n_wr < 8) begin
                    wa_log[n_wr] = wrAddr;
                    wd_log[n_wr] = wrData;
                end
                if (n_wr == 0) first_wr_cyc = c;
                n_wr++;
                regs[wrAddr] = wrData;
            end
            if (prev == 8'hFF && address == 8'h00) wrap_seen = 1'b1;
            prev = address;
            if (halted) begin
                end_halted = 1'b1;
                end_addr   = address;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (c == start_at) start = 1'b1;
        end
    endtask

    initial begin
        bit bad_wr, bad_busy;
        logic [7:0] exp_wa [4];
        logic [7:0] exp_wd [4];

        vecs[0]  = '{16'h4F78, 1, 4'hF, 8'h07};  // ADD 0x0A+0xFD
        vecs[1]  = '{16'h5130, 1, 4'h1, 8'hFD};  // NEG 3
        vecs[2]  = '{16'h8250, 1, 4'h2, 8'h0A};  // SHL 5
        vecs[3]  = '{16'hB453, 1, 4'h4, 8'h01};  // GT 5>3
        vecs[4]  = '{16'hB435, 1, 4'h4, 8'h00};  // GT 3>5
        vecs[5]  = '{16'h06A5, 1, 4'h6, 8'hA5};  // SET
        vecs[6]  = '{16'h2980, 1, 4'h9, 8'hFD};  // COPY R8
        vecs[7]  = '{16'h6A78, 1, 4'hA, 8'h08};  // AND
        vecs[8]  = '{16'h7B78, 1, 4'hB, 8'hFF};  // OR
        vecs[9]  = '{16'h1F78, 0, 4'h0, 8'h00};  // NOP 0001
        vecs[10] = '{16'hFF78, 0, 4'h0, 8'h00};  // NOP 1111
        vecs[11] = '{16'hB433, 1, 4'h4, 8'h00};  // GT equal
        vecs[12] = '{16'h8C80, 1, 4'hC, 8'hFA};  // SHL drops MSB

        fill_imem(16'hE000);
        init_regs();

        // Reset takes effect before any clock edge.
        start = 1'b0;
        reset = 1'b1;
        #2;
        check("rst_address", 32'(address), 32'h0);
        check("rst_wren",    32'(wrEn),    32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_halted",  32'(halted),  32'h0);
        check("rst_rdaddr",  32'({rdAddrA, rdAddrB}), 32'h0);
        check("rst_wraddr",  32'(wrAddr),  32'h0);
        check("rst_wrdata",  32'(wrData),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy",    32'(busy),    32'h0);
        check("idle_address", 32'(address), 32'h0);

        // Single-instruction vectors, each followed by HALT at address 1.
        for (int i = 0; i < 13; i++) begin
            reset_dut();
            init_regs();
            fill_imem(16'hE000);
            imem[0] = vecs[i].instr;
            run(20, 0);
            check($sformatf("vec%0d_nwr", i), 32'(n_wr), 32'(vecs[i].exp_nwr));
            if (vecs[i].exp_nwr == 1) begin
                check($sformatf("vec%0d_data", i), 32'(wd_log[0]), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_addr", i), 32'(wa_log[0]), 32'(vecs[i].exp_addr));
                check($sformatf("vec%0d_cycle", i), 32'(first_wr_cyc), 32'd4);
            end
            check($sformatf("vec%0d_halted", i), 32'(end_halted), 32'h1);
            check($sformatf("vec%0d_endaddr", i), 32'(end_addr), 32'h1);
        end

        // Five-instruction program ending in HALT.
        reset_dut();
        init_regs();
        fill_imem(16'h0000);
        imem[0] = 16'h0102;
        imem[1] = 16'h2F10;
        imem[2] = 16'h0203;
        imem[3] = 16'h4F21;
        imem[4] = 16'hE000;
        exp_wa = '{8'd1, 8'd15, 8'd2, 8'd15};
        exp_wd = '{8'd2, 8'd2,  8'd3, 8'd5};
        run(40, 0);
        check("prog_nwr", 32'(n_wr), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("prog_wa%0d", i), 32'(wa_log[i]), 32'(exp_wa[i]));
            check($sformatf("prog_wd%0d", i), 32'(wd_log[i]), 32'(exp_wd[i]));
        end
        check("prog_halted",  32'(end_halted), 32'h1);
        check("prog_endaddr", 32'(end_addr),   32'h4);

        // start during DECODE is ignored; start in HALT restarts from address 0.
        reset_dut();
        init_regs();
        fill_imem(16'hE000);
        imem[0] = 16'h0111;
        run(20, 2);
        check("sdec_nwr",    32'(n_wr),         32'd1);
        check("sdec_data",   32'(wd_log[0]),    32'h11);
        check("sdec_cycle",  32'(first_wr_cyc), 32'd4);
        check("sdec_halted", 32'(end_halted),   32'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_halted",  32'(halted),  32'h0);
        check("restart_address", 32'(address), 32'h0);
        check("restart_busy",    32'(busy),    32'h1);
        end_halted = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (halted) begin
                end_halted = 1'b1;
                break;
            end
        end
        check("restart_rehalt", 32'(end_halted), 32'h1);

        // Reset in EXECUTE of an ADD aborts it.
        reset_dut();
        init_regs();
        fill_imem(16'hE000);
        imem[0] = 16'h0133;
        imem[1] = 16'h0244;
        imem[2] = 16'h4F12;
        run(11, 0);
        check("abort_pre_nwr",  32'(n_wr),    32'd2);
        check("abort_pre_busy", 32'(busy),    32'h1);
        check("abort_pre_addr", 32'(address), 32'h2);
        reset = 1'b1;
        #1;
        check("abort_address", 32'(address), 32'h0);
        check("abort_busy",    32'(busy),    32'h0);
        check("abort_wren",    32'(wrEn),    32'h0);
        check("abort_rdaddr",  32'({rdAddrA, rdAddrB}), 32'h0);
        check("abort_wrdata",  32'(wrData),  32'h0);
        bad_wr   = 1'b0;
        bad_busy = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (wrEn) bad_wr = 1'b1;
            if (busy || address != 8'h00) bad_busy = 1'b1;
        end
        check("abort_no_write", 32'(bad_wr),   32'h0);
        check("abort_idle",     32'(bad_busy), 32'h0);
        check("abort_r15",      32'(regs[15]), 32'h0);

        // 256 NOPs: no writes, PC wraps, busy never drops.
        reset_dut();
        init_regs();
        fill_imem(16'h1000);
        run(1030, 0);
        check("nop_nwr",    32'(n_wr),       32'd0);
        check("nop_busy",   32'(busy_ok),    32'h1);
        check("nop_wrap",   32'(wrap_seen),  32'h1);
        check("nop_halted", 32'(end_halted), 32'h0);
        check("nop_addr",   32'(address),    32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
